// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - 32x32 signed multiply (radix-2 Booth) / signed divide (restoring), fixed 34-edge latency.
module mul_div_unit (
    input  logic        Clock,
    input  logic        clear,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] Zhigh,
    output logic [31:0] Zlow
);

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

    state_t      state, state_next;
    logic [5:0]  count;
    logic        op_q;
    logic [31:0] a_q, b_q;
    logic [31:0] hi, lo;
    logic        q_m1;

    logic [31:0] b_mag;
    logic [32:0] booth_sum;
    logic        rem_ge;
    logic [31:0] rem_sub;
    logic [31:0] quo_fix, rem_fix;

    always_ff @(posedge Clock) begin
        if (clear) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (count == 6'd31) state_next = FIXUP;
            FIXUP:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Booth step on the 33-bit sign-extended high half; the shift happens in the register update.
    always_comb begin
        case ({lo[0], q_m1})
            2'b01:   booth_sum = {hi[31], hi} + {a_q[31], a_q};
            2'b10:   booth_sum = {hi[31], hi} - {a_q[31], a_q};
            default: booth_sum = {hi[31], hi};
        endcase
    end

    // Divide works on magnitudes: hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
    // The remainder stays below the divisor magnitude (at most 2^31), so 32-bit subtraction suffices once rem_ge holds.
    always_comb begin
        b_mag   = b_q[31] ? -b_q : b_q;
        rem_ge  = ({hi, lo[31]} >= {1'b0, b_mag});
        rem_sub = {hi[30:0], lo[31]} - b_mag;
        quo_fix = (a_q[31] ^ b_q[31]) ? -lo : lo;
        rem_fix = a_q[31] ? -hi : hi;
    end

    always_ff @(posedge Clock) begin
        if (clear) begin
            count       <= 6'd0;
            op_q        <= 1'b0;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            hi          <= 32'd0;
            lo          <= 32'd0;
            q_m1        <= 1'b0;
            Zhigh       <= 32'd0;
            Zlow        <= 32'd0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        a_q   <= A;
                        b_q   <= B;
                        count <= 6'd0;
                        hi    <= 32'd0;
                        q_m1  <= 1'b0;
                        lo    <= op ? (A[31] ? -A : A) : B;
                    end
                end
                CALC: begin
                    count <= count + 6'd1;
                    if (!op_q) begin
                        hi   <= booth_sum[32:1];
                        lo   <= {booth_sum[0], lo[31:1]};
                        q_m1 <= lo[0];
                    end else if (rem_ge) begin
                        hi <= rem_sub;
                        lo <= {lo[30:0], 1'b1};
                    end else begin
                        hi <= {hi[30:0], lo[31]};
                        lo <= {lo[30:0], 1'b0};
                    end
                end
                FIXUP: begin
                    if (!op_q) begin
                        Zhigh       <= hi;
                        Zlow        <= lo;
                        div_by_zero <= 1'b0;
                    end else if (b_q == 32'd0) begin
                        Zhigh       <= a_q;
                        Zlow        <= 32'hFFFF_FFFF;
                        div_by_zero <= 1'b1;
                    end else begin
                        Zhigh       <= rem_fix;
                        Zlow        <= quo_fix;
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed and random checks of mul_div_unit against a plain-arithmetic reference.
module tb_mul_div_unit;

    logic        Clock;
    logic        clear;
    logic        start;
    logic        op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] Zhigh;
    logic [31:0] Zlow;

    int checks = 0;
    int errors = 0;

    mul_div_unit dut (
        .Clock       (Clock),
        .clear       (clear),
        .start       (start),
        .op          (op),
        .A           (A),
        .B           (B),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .Zhigh       (Zhigh),
        .Zlow        (Zlow)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: signed 64-bit arithmetic; SV division truncates toward zero and % takes the dividend's sign.
    task automatic model(input logic o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eh, output logic [31:0] el, output logic ez);
        longint      sa, sb;
        logic [63:0] p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ez = 1'b0;
        if (!o) begin
            p  = sa * sb;
            eh = p[63:32];
            el = p[31:0];
        end else if (b == 32'd0) begin
            eh = a;
            el = 32'hFFFF_FFFF;
            ez = 1'b1;
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            eh = r[31:0];
            el = q[31:0];
        end
    endtask

    task automatic run_op(input string tag, input logic o, input logic [31:0] a, input logic [31:0] b,
                          input bit noise);
        logic [31:0] eh, el;
        logic        ez;
        int          early;
        model(o, a, b, eh, el, ez);
        early = 0;
        op = o; A = a; B = b; start = 1'b1;
        @(posedge Clock); #1;
        start = 1'b0;
        if (noise) begin
            A  = $urandom;
            B  = $urandom;
            op = ~o;
        end
        chk({tag, " busy_after_start"}, 64'(busy), 64'd1);
        for (int e = 2; e <= 34; e++) begin
            start = (noise && (e == 6 || e == 20)) ? 1'b1 : 1'b0;
            @(posedge Clock); #1;
            if (e < 34 && done) early++;
        end
        start = 1'b0;
        chk({tag, " early_done"}, 64'(early), 64'd0);
        chk({tag, " done_at_35"}, 64'(done), 64'd1);
        chk({tag, " Zhigh"}, 64'(Zhigh), 64'(eh));
        chk({tag, " Zlow"}, 64'(Zlow), 64'(el));
        chk({tag, " div_by_zero"}, 64'(div_by_zero), 64'(ez));
        // start during DONE must not launch a new operation
        start = 1'b1;
        @(posedge Clock); #1;
        start = 1'b0;
        chk({tag, " done_one_cycle"}, 64'(done), 64'd0);
        chk({tag, " idle_after_done"}, 64'(busy), 64'd0);
        chk({tag, " Zlow_hold"}, 64'(Zlow), 64'(el));
    endtask

    initial begin
        int          stray;
        logic        ro;
        logic [31:0] ra, rb;

        clear = 1'b1; start = 1'b0; op = 1'b0; A = 32'd0; B = 32'd0;
        repeat (2) @(posedge Clock);
        #1;
        clear = 1'b0;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset dbz", 64'(div_by_zero), 64'd0);
        chk("reset Zhigh", 64'(Zhigh), 64'd0);
        chk("reset Zlow", 64'(Zlow), 64'd0);

        run_op("mul_7_m3", 1'b0, 32'd7, 32'hFFFF_FFFD, 1'b0);
        chk("mul_7_m3 const_hi", 64'(Zhigh), 64'hFFFF_FFFF);
        chk("mul_7_m3 const_lo", 64'(Zlow), 64'hFFFF_FFEB);
        run_op("mul_min_min", 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0);
        chk("mul_min_min const_hi", 64'(Zhigh), 64'h4000_0000);
        run_op("div_m17_5", 1'b1, 32'hFFFF_FFEF, 32'd5, 1'b0);
        chk("div_m17_5 const_lo", 64'(Zlow), 64'hFFFF_FFFD);
        chk("div_m17_5 const_hi", 64'(Zhigh), 64'hFFFF_FFFE);
        run_op("div_100_0", 1'b1, 32'd100, 32'd0, 1'b0);
        chk("div_100_0 const_dbz", 64'(div_by_zero), 64'd1);
        run_op("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("div_min_m1 const_lo", 64'(Zlow), 64'h8000_0000);
        chk("div_min_m1 const_hi", 64'(Zhigh), 64'h0);

        run_op("noise_mul", 1'b0, 32'h1234_5678, 32'hFEDC_BA98, 1'b1);
        run_op("noise_div", 1'b1, 32'h8765_4321, 32'h0000_1234, 1'b1);

        // Abort after 10 iterations: outputs clear next cycle and no done ever appears.
        op = 1'b0; A = 32'd123; B = 32'd456; start = 1'b1;
        @(posedge Clock); #1;
        start = 1'b0;
        repeat (10) @(posedge Clock);
        #1;
        clear = 1'b1;
        @(posedge Clock); #1;
        clear = 1'b0;
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort Zhigh", 64'(Zhigh), 64'd0);
        chk("abort Zlow", 64'(Zlow), 64'd0);
        chk("abort done", 64'(done), 64'd0);
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge Clock); #1;
            if (done || busy) stray++;
        end
        chk("abort no_done", 64'(stray), 64'd0);

        run_op("mul_6_7", 1'b0, 32'd6, 32'd7, 1'b0);
        chk("mul_6_7 const_lo", 64'(Zlow), 64'h2A);

        for (int n = 0; n < 40; n++) begin
            ro = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = $urandom;
            case (n % 8)
                0: rb = 32'd0;
                1: ra = 32'h8000_0000;
                2: rb = 32'h8000_0000;
                3: rb = $urandom_range(1, 15);
                4: rb = -32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op($sformatf("rand%0d", n), ro, ra, rb, n[0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 Port `Clock`: input, 1 bit; rising-edge system clock.
REQ-003 Port `clear`: input, 1 bit; synchronous active-high reset.
REQ-004 Port `start`: input, 1 bit; request a new operation; sampled only in IDLE.
REQ-005 Port `op`: input, 1 bit; 0 = signed MUL, 1 = signed DIV.
REQ-006 Port `A`: input, 32 bits; operand from the Y register (multiplicand / dividend).
REQ-007 Port `B`: input, 32 bits; operand from the bus (multiplier / divisor).
REQ-008 Port `busy`: output, 1 bit; high in every state except IDLE.
REQ-009 Port `done`: output, 1 bit; one-cycle pulse when the result is valid.
REQ-010 Port `div_by_zero`: output, 1 bit; set for a DIV whose captured B is 0.
REQ-011 Port `Zhigh`: output, 32 bits; product[63:32] (MUL) or remainder (DIV); feeds the Zhigh register.
REQ-012 Port `Zlow`: output, 32 bits; product[31:0] (MUL) or quotient (DIV); feeds the Zlow register.

Function
REQ-013 FSM states SHALL be IDLE, CALC, FIXUP and DONE, with a 6-bit iteration counter.
REQ-014 In IDLE with start=1, the edge SHALL capture A, B and op into internal registers, clear the counter and go to CALC.
REQ-015 Changes on A, B or op after the capture edge SHALL NOT affect the result.
REQ-016 CALC SHALL perform exactly one iteration per edge for 32 edges, then go to FIXUP.
REQ-017 MUL SHALL use radix-2 Booth recoding on a 65-bit accumulator {hi, lo, q-1} with arithmetic right shift and 33-bit add/sub.
REQ-018 DIV SHALL operate on operand magnitudes using restoring or non-restoring shift-subtract, one quotient bit per iteration.
REQ-019 FIXUP SHALL apply signs: quotient negated if the operand signs differ; remainder takes the dividend's sign; quotient truncates toward zero.
REQ-020 FIXUP SHALL load Zhigh/Zlow and go to DONE; DONE SHALL assert done for one cycle and return to IDLE.
REQ-021 Latency: done SHALL be high in the cycle after edge 34, counting the start-sampling edge as edge 1; the same latency applies to every op and operand.
REQ-022 Zhigh, Zlow and div_by_zero SHALL hold their values from DONE until the next accepted start.
REQ-023 start while busy SHALL be ignored, with no queuing and no effect on the current operation.
REQ-024 Divide by zero: Zlow = 0xFFFFFFFF, Zhigh = captured A, div_by_zero = 1, same latency.
REQ-025 DIV 0x80000000 / 0xFFFFFFFF SHALL give Zlow = 0x80000000 (wrap) and Zhigh = 0, with no flag.
REQ-026 MUL SHALL produce the exact 64-bit two's-complement product, including for 0x80000000 operands.
REQ-027 start in the same cycle as DONE SHALL be ignored; start is accepted only once the FSM is back in IDLE.

Reset
REQ-028 clear=1 at an edge SHALL force IDLE, counter = 0, busy = 0, done = 0, div_by_zero = 0, Zhigh = 0, Zlow = 0.
REQ-029 clear SHALL take priority over start and over any in-flight operation; an aborted operation SHALL NOT produce done.
REQ-030 After clear deasserts, the first start SHALL behave exactly as from power-up reset.

Verification
REQ-031 MUL A=7, B=0xFFFFFFFD -> Zhigh = 0xFFFFFFFF, Zlow = 0xFFFFFFEB; done after edge 34 for exactly one cycle.
REQ-032 MUL A=B=0x80000000 -> Zhigh = 0x40000000, Zlow = 0x00000000.
REQ-033 DIV A=0xFFFFFFEF (-17), B=5 -> Zlow = 0xFFFFFFFD (-3), Zhigh = 0xFFFFFFFE (-2), div_by_zero = 0.
REQ-034 DIV A=100, B=0 -> Zlow = 0xFFFFFFFF, Zhigh = 0x00000064, div_by_zero = 1; then DIV 0x80000000 / 0xFFFFFFFF -> Zlow = 0x80000000, Zhigh = 0, div_by_zero = 0.
REQ-035 start pulses during CALC -> ignored, and the first result is unchanged; clear at iteration 10 -> busy = 0 and Z outputs = 0 next cycle, with no done.
REQ-036 A new MUL 6*7 issued after that clear -> Zlow = 0x2A, Zhigh = 0, with the full 34-edge latency.
